// File: rtl/pipelined_addsub_nb.sv
// Pipelined N-bit adder/subtractor with NZCV flags and valid/ready flow control.
// Operands are registered on acceptance, then the carry chain is resolved in STAGES segments.
module pipelined_addsub_nb #(
   parameter int N      = 32,
   parameter int STAGES = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [1:0]   op,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] result,
   output logic [3:0]   flags
);

   localparam int W = N / STAGES;

   // NZCV from a complete result, the carry out of the MSB and the carry into the MSB.
   function automatic logic [3:0] nzcv_f(input logic [N-1:0] res, input logic c_out,
                                         input logic c_msb);
      nzcv_f = {res[N-1], (res == {N{1'b0}}), c_out, c_out ^ c_msb};
   endfunction

   // Rank i holds the operands and partial sum waiting for segment i.
   logic         v_r   [STAGES];
   logic [N-1:0] a_r   [STAGES];
   logic [N-1:0] b_r   [STAGES];
   logic [N-1:0] sum_r [STAGES];
   logic         c_r   [STAGES];

   logic         out_valid_r;
   logic [N-1:0] result_r;
   logic [3:0]   flags_r;

   logic         en_s;
   logic [N-1:0] b_eff_s;
   logic         cin_eff_s;
   logic [W:0]   seg_s    [STAGES];
   logic [N-1:0] sum_nx_s [STAGES];
   logic         carry_s  [STAGES];
   logic         c_msb_s;

   assign en_s      = !out_valid_r || out_ready;
   assign in_ready  = en_s && !reset;
   assign out_valid = out_valid_r;
   assign result    = result_r;
   assign flags     = flags_r;

   // Operation decode: subtraction inverts b, carry-in chosen by op.
   always_comb begin
      b_eff_s   = b;
      cin_eff_s = 1'b0;
      case (op)
         2'b00: begin
            b_eff_s   = b;
            cin_eff_s = 1'b0;
         end
         2'b01: begin
            b_eff_s   = b;
            cin_eff_s = cin;
         end
         2'b10: begin
            b_eff_s   = ~b;
            cin_eff_s = 1'b1;
         end
         2'b11: begin
            b_eff_s   = ~b;
            cin_eff_s = cin;
         end
         default: begin
            b_eff_s   = b;
            cin_eff_s = 1'b0;
         end
      endcase
   end

   // Segment adders: segment i fills bits [i*W +: W] of the partial sum.
   always_comb begin
      for (int i = 0; i < STAGES; i++) begin
         seg_s[i]    = {1'b0, a_r[i][i*W +: W]} + {1'b0, b_r[i][i*W +: W]}
                     + {{W{1'b0}}, c_r[i]};
         sum_nx_s[i] = sum_r[i];
         sum_nx_s[i][i*W +: W] = seg_s[i][W-1:0];
         carry_s[i]  = seg_s[i][W];
      end
   end

   // Carry into the MSB recovered from the MSB sum bit and its operand bits.
   assign c_msb_s = sum_nx_s[STAGES-1][N-1] ^ a_r[STAGES-1][N-1] ^ b_r[STAGES-1][N-1];

   // Pipeline ranks and output register; everything shifts together when en_s is high.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < STAGES; i++) begin
            v_r[i]   <= 1'b0;
            a_r[i]   <= {N{1'b0}};
            b_r[i]   <= {N{1'b0}};
            sum_r[i] <= {N{1'b0}};
            c_r[i]   <= 1'b0;
         end
         out_valid_r <= 1'b0;
         result_r    <= {N{1'b0}};
         flags_r     <= 4'b0000;
      end else if (en_s) begin
         v_r[0]   <= in_valid;
         sum_r[0] <= {N{1'b0}};
         if (in_valid) begin
            a_r[0] <= a;
            b_r[0] <= b_eff_s;
            c_r[0] <= cin_eff_s;
         end else begin
            a_r[0] <= a_r[0];
            b_r[0] <= b_r[0];
            c_r[0] <= c_r[0];
         end
         for (int i = 1; i < STAGES; i++) begin
            v_r[i]   <= v_r[i-1];
            a_r[i]   <= a_r[i-1];
            b_r[i]   <= b_r[i-1];
            sum_r[i] <= sum_nx_s[i-1];
            c_r[i]   <= carry_s[i-1];
         end
         out_valid_r <= v_r[STAGES-1];
         // Bubbles leave the last result in place so idle outputs never show garbage.
         if (v_r[STAGES-1]) begin
            result_r <= sum_nx_s[STAGES-1];
            flags_r  <= nzcv_f(sum_nx_s[STAGES-1], carry_s[STAGES-1], c_msb_s);
         end else begin
            result_r <= result_r;
            flags_r  <= flags_r;
         end
      end else begin
         out_valid_r <= out_valid_r;
         result_r    <= result_r;
         flags_r     <= flags_r;
      end
   end

endmodule

// File: tb/tb_pipelined_addsub_nb.sv
// Bench for pipelined_addsub_nb: directed vector table, random stream with a stall,
// and reset with operations in flight; a scoreboard checks every delivered result.
module tb_pipelined_addsub_nb;

   localparam int N      = 32;
   localparam int STAGES = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [1:0]    op;
   logic [N-1:0]  a;
   logic [N-1:0]  b;
   logic          cin;
   logic          out_valid;
   logic          out_ready;
   logic [N-1:0]  result;
   logic [3:0]    flags;

   always #5 clk = ~clk;

   pipelined_addsub_nb #(.N(N), .STAGES(STAGES)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .a(a), .b(b), .cin(cin), .out_valid(out_valid),
      .out_ready(out_ready), .result(result), .flags(flags)
   );

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic        cin;
      logic [31:0] res;
      logic [3:0]  flg;
   } vec_t;

   typedef struct {
      logic [31:0] res;
      logic [3:0]  flg;
   } exp_t;

   vec_t vecs [7];
   exp_t sbq [$];
   exp_t mon_e;
   int   errors    = 0;
   int   checks    = 0;
   int   out_count = 0;

   // Reference: 33-bit sum, overflow from operand/result signs.
   function automatic exp_t model(input logic [1:0] mop, input logic [31:0] ma,
                                  input logic [31:0] mb, input logic mcin);
      exp_t        e;
      logic [31:0] be;
      logic        ci;
      logic [32:0] full;
      be   = mop[1] ? ~mb : mb;
      ci   = (mop == 2'b00) ? 1'b0 : ((mop == 2'b10) ? 1'b1 : mcin);
      full = {1'b0, ma} + {1'b0, be} + {32'd0, ci};
      e.res = full[31:0];
      e.flg = {full[31], (full[31:0] == 32'd0), full[32],
               (ma[31] == be[31]) && (full[31] != ma[31])};
      return e;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard: pop on output transfer, push on input transfer, flush on reset.
   always @(negedge clk) begin
      if (reset) begin
         sbq.delete();
      end else begin
         if (out_valid && out_ready) begin
            out_count++;
            if (sbq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_unexpected: got output %h expected none", result);
            end else begin
               mon_e = sbq.pop_front();
               check("sb_result", result, mon_e.res);
               check("sb_flags", {28'd0, flags}, {28'd0, mon_e.flg});
            end
         end
         if (in_valid && in_ready) sbq.push_back(model(op, a, b, cin));
      end
   end

   task automatic run_vec(input int i);
      int lat;
      @(posedge clk); #1;
      in_valid  = 1'b1;
      op        = vecs[i].op;
      a         = vecs[i].a;
      b         = vecs[i].b;
      cin       = vecs[i].cin;
      out_ready = 1'b1;
      @(negedge clk);
      check($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      a        = 32'hDEAD_BEEF;
      b        = 32'h1234_5678;
      lat      = -1;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (out_valid) begin
            lat = k;
            break;
         end
      end
      check($sformatf("vec%0d_latency", i), lat, 32'd4);
      check($sformatf("vec%0d_result", i), result, vecs[i].res);
      check($sformatf("vec%0d_flags", i), {28'd0, flags}, {28'd0, vecs[i].flg});
      @(posedge clk);
   endtask

   logic [1:0]  st_op  [8];
   logic [31:0] st_a   [8];
   logic [31:0] st_b   [8];
   logic        st_cin [8];
   logic [31:0] held_r;
   logic [3:0]  held_f;
   logic        acc;
   logic        stale;
   int          idx;
   int          base_count;

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      op        = 2'b00;
      a         = 32'd0;
      b         = 32'd0;
      cin       = 1'b0;

      vecs[0] = '{2'b10, 32'd5,          32'd3, 1'b0, 32'h0000_0002, 4'b0010};
      vecs[1] = '{2'b10, 32'd3,          32'd5, 1'b0, 32'hFFFF_FFFE, 4'b1000};
      vecs[2] = '{2'b00, 32'h7FFF_FFFF,  32'd1, 1'b0, 32'h8000_0000, 4'b1001};
      vecs[3] = '{2'b00, 32'hFFFF_FFFF,  32'd1, 1'b0, 32'h0000_0000, 4'b0110};
      vecs[4] = '{2'b11, 32'd0,          32'd0, 1'b0, 32'hFFFF_FFFF, 4'b1000};
      vecs[5] = '{2'b01, 32'd1,          32'd1, 1'b1, 32'h0000_0003, 4'b0000};
      vecs[6] = '{2'b10, 32'd10,         32'd4, 1'b0, 32'h0000_0006, 4'b0010};

      for (int i = 0; i < 8; i++) begin
         st_op[i]  = 2'($urandom_range(0, 3));
         st_a[i]   = $urandom;
         st_b[i]   = $urandom;
         st_cin[i] = 1'($urandom_range(0, 1));
      end

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_result", result, 32'd0);
      check("rst_flags", {28'd0, flags}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

      for (int i = 0; i < 6; i++) run_vec(i);

      // Back-to-back stream, consumer stalls for cycles 6..8.
      #1;
      idx        = 0;
      base_count = out_count;
      for (int cyc = 0; cyc < 40; cyc++) begin
         if (idx < 8) begin
            in_valid = 1'b1;
            op       = st_op[idx];
            a        = st_a[idx];
            b        = st_b[idx];
            cin      = st_cin[idx];
         end else begin
            in_valid = 1'b0;
         end
         out_ready = !(cyc >= 6 && cyc <= 8);
         @(negedge clk);
         acc = in_valid && in_ready;
         if (cyc == 6) begin
            check("stall_out_valid", {31'd0, out_valid}, 32'd1);
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
            held_r = result;
            held_f = flags;
         end
         if (cyc == 7 || cyc == 8) begin
            check($sformatf("stall_hold_result_c%0d", cyc), result, held_r);
            check($sformatf("stall_hold_flags_c%0d", cyc), {28'd0, flags}, {28'd0, held_f});
            check($sformatf("stall_in_ready_c%0d", cyc), {31'd0, in_ready}, 32'd0);
         end
         @(posedge clk); #1;
         if (acc) idx++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check("stream_accepted", idx, 32'd8);
      check("stream_delivered", out_count - base_count, 32'd8);

      // Reset with three operations in flight.
      for (int j = 0; j < 3; j++) begin
         in_valid = 1'b1;
         op       = st_op[j];
         a        = st_a[j] ^ 32'h5555_AAAA;
         b        = st_b[j];
         cin      = st_cin[j];
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      reset    = 1'b1;
      @(negedge clk);
      check("inflight_rst_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("inflight_rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("inflight_rst_result", result, 32'd0);
      check("inflight_rst_flags", {28'd0, flags}, 32'd0);
      check("inflight_rst_in_ready_after", {31'd0, in_ready}, 32'd1);
      stale = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (out_valid) stale = 1'b1;
      end
      check("no_stale_result", {31'd0, stale}, 32'd0);

      run_vec(6);

      repeat (10) @(posedge clk);
      @(negedge clk);
      check("scoreboard_empty", sbq.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipelined_addsub_nb.md
# pipelined_addsub_nb

Parametrised, pipelined N-bit adder/subtractor with ARM-style NZCV flag generation and valid/ready flow control. It is the sequential successor of the ripple full-subtractor: the carry/borrow chain is cut into STAGES registered segments so wide operands close timing. It accepts one operation per cycle and feeds the datapath's flag and result logic.

## Interface
- N, default 32: operand/result width; must satisfy N % STAGES == 0.
- STAGES, default 4: number of carry-chain segments, each N/STAGES bits wide. This is also the latency in cycles; must be ≥ 1.

- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operation presented on a, b, op, cin.
- in_ready  out  1  block can accept an operation this cycle.
- op  in  2  00 ADD (a+b), 01 ADC (a+b+cin), 10 SUB (a−b), 11 SBC (a−b−!cin).
- a, b  in  N  operands.
- cin  in  1  ARM carry flag input; used only by ADC and SBC.
- out_valid  out  1  result and flags are valid.
- out_ready  in  1  consumer accepts the result this cycle.
- result  out  N  sum or difference, modulo 2^N.
- flags  out  4  {N, Z, C, V}.

## Operation
- Subtraction is computed as a + ~b + carry_in.
  - SUB uses carry_in = 1.
  - SBC uses carry_in = cin.
  - ADD uses carry_in = 0.
  - ADC uses carry_in = cin.
- C is the carry out of bit N−1, following ARM convention. For SUB/SBC, C = 1 means no borrow.
- V = carry into bit N−1 XOR carry out of bit N−1.
- N = result[N−1].
- Z = (result == 0).
- Pipeline structure:
  - Stage k (0-based) computes bits [(k+1)·N/STAGES−1 : k·N/STAGES] from the registered carry of stage k−1.
  - Not-yet-processed high operand bits and already-computed low result bits travel alongside in registers.
  - Each rank has its own valid bit.
- Advance rule: a global enable en = !out_valid || out_ready.
  - When en = 1, all ranks shift by one.
  - When en = 0, all ranks hold.
  - Bubbles are not compressed.
- in_ready = en && !reset. A transfer occurs when in_valid && in_ready. When no transfer occurs, a bubble (valid = 0) enters rank 0.
- Results emerge strictly in issue order. No operation is dropped or duplicated under any out_ready pattern.
- Flags are computed in the final rank from that rank's complete result and final carries. Flags are never taken from a partial result.
- STAGES = 1 degenerates to a single registered adder stage with latency 1.

## Timing
- Reset (synchronous, applied while reset = 1 at a clock edge):
  - All valid bits are cleared.
  - result = 0, flags = 4'b0000, out_valid = 0.
  - Any in-flight operations are discarded.
  - in_ready = 0 while reset is high.
  - in_ready = 1 in the first cycle after reset deasserts.
- Latency: an operation accepted at edge t appears with out_valid = 1 after edge t+STAGES, provided en stays 1. Each stall cycle adds one cycle.
- Throughput: one operation per cycle while out_ready = 1.
- out_valid && !out_ready:
  - result and flags are held stable.
  - in_ready = 0 combinationally in the same cycle.
- out_ready with out_valid = 0 has no effect. The pipeline keeps advancing so that bubbles drain.
- Simultaneous accept and output transfer in the same cycle is legal and required for full throughput.
- Operand inputs are sampled only on an accepting edge. They may change freely otherwise.

## Test plan
All scenarios use N = 32, STAGES = 4.
- SUB a=5, b=3 → result 0x00000002, flags 0010, out_valid exactly 4 cycles after acceptance.
- SUB a=3, b=5 → result 0xFFFFFFFE, flags 1000 (borrow, so C = 0).
- ADD a=0x7FFFFFFF, b=1 → result 0x80000000, flags 1001. ADD a=0xFFFFFFFF, b=1 → result 0, flags 0110.
- SBC a=0, b=0, cin=0 → result 0xFFFFFFFF, flags 1000. ADC a=1, b=1, cin=1 → result 3, flags 0000.
- Back-to-back stream of 8 random ops with out_ready low for 3 cycles mid-stream:
  - in_ready drops in the first stalled cycle.
  - Results match the reference model in order, with no loss or duplication.
  - result is held stable during the stall.
- Reset asserted with 3 ops in flight:
  - Next cycle: out_valid = 0, result = 0, flags = 0.
  - No stale result appears afterward.
  - A new SUB 10−4 issued after reset returns 6 with flags 0010.
